// File: rtl/dsp_tx_pkg.sv
// Shared types, register map and helpers for the TX interpolating DSP path.
package dsp_tx_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned SET_ADDR_W = 8;
    localparam int unsigned SET_DATA_W = 32;
    localparam int unsigned RATE_W     = 8;
    localparam int unsigned SHIFT_W    = 4;

    localparam logic [SET_ADDR_W-1:0] REG_PHASE_INC = 8'd0;
    localparam logic [SET_ADDR_W-1:0] REG_SCALE     = 8'd1;
    localparam logic [SET_ADDR_W-1:0] REG_RATE      = 8'd2;

    localparam logic [SAMPLE_W-1:0] SCALE_UNITY = 16'h4000;

    // One I/Q sample as carried on the TX buffer bus.
    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } iq_sample_t;

    // Ceil(log2(rate)); rates 0 and 1 both mean no interpolation.
    function automatic logic [SHIFT_W-1:0] clog2_rate(input logic [RATE_W-1:0] rate);
        logic [SHIFT_W-1:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            if ((9'd1 << k) < {1'b0, rate}) begin
                s = SHIFT_W'(k + 1);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/tx_cic_interp.sv
// One channel of the 2-stage CIC interpolator: slow-rate combs, zero-stuff,
// full-rate integrators, normalising shift with 16-bit saturation.
module tx_cic_interp
    import dsp_tx_pkg::*;
#(
    parameter int unsigned WIDTH_INT = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] din,
    input  logic [SHIFT_W-1:0]         shift,
    output logic signed [SAMPLE_W-1:0] dout_c
);

    logic signed [WIDTH_INT-1:0] din_ext;
    logic signed [WIDTH_INT-1:0] x_prev_q,  x_prev_d;
    logic signed [WIDTH_INT-1:0] comb1_q,   comb1_d;
    logic signed [WIDTH_INT-1:0] c1_prev_q, c1_prev_d;
    logic signed [WIDTH_INT-1:0] comb2_q,   comb2_d;
    logic signed [WIDTH_INT-1:0] integ1_q,  integ1_d;
    logic signed [WIDTH_INT-1:0] integ2_q,  integ2_d;
    logic                        en2_q,     en2_d;
    logic signed [WIDTH_INT-1:0] shifted;

    assign din_ext = {{(WIDTH_INT-SAMPLE_W){din[SAMPLE_W-1]}}, din};

    // Combs fire once per input sample and emit zero otherwise (zero-stuffing);
    // integrators accumulate every cycle and wrap freely.
    always_comb begin
        x_prev_d  = x_prev_q;
        c1_prev_d = c1_prev_q;
        comb1_d   = '0;
        comb2_d   = '0;
        en2_d     = en;
        integ1_d  = integ1_q + comb2_q;
        integ2_d  = integ2_q + integ1_q;
        if (en) begin
            comb1_d  = din_ext - x_prev_q;
            x_prev_d = din_ext;
        end
        if (en2_q) begin
            comb2_d   = comb1_q - c1_prev_q;
            c1_prev_d = comb1_q;
        end
        if (clr) begin
            x_prev_d  = '0;
            c1_prev_d = '0;
            comb1_d   = '0;
            comb2_d   = '0;
            en2_d     = 1'b0;
            integ1_d  = '0;
            integ2_d  = '0;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_q  <= '0;
            c1_prev_q <= '0;
            comb1_q   <= '0;
            comb2_q   <= '0;
            en2_q     <= 1'b0;
            integ1_q  <= '0;
            integ2_q  <= '0;
        end else begin
            x_prev_q  <= x_prev_d;
            c1_prev_q <= c1_prev_d;
            comb1_q   <= comb1_d;
            comb2_q   <= comb2_d;
            en2_q     <= en2_d;
            integ1_q  <= integ1_d;
            integ2_q  <= integ2_d;
        end
    end

    // Remove the CIC gain of R, then clamp into the 16-bit sample range.
    always_comb begin
        shifted = integ2_q >>> shift;
        if ((&shifted[WIDTH_INT-1:SAMPLE_W-1]) || (~|shifted[WIDTH_INT-1:SAMPLE_W-1])) begin
            dout_c = shifted[SAMPLE_W-1:0];
        end else begin
            dout_c = shifted[WIDTH_INT-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

endmodule

// File: rtl/dsp_tx_interp.sv
// TX DSP core: settings registers, sample strober, NCO, two CIC channels and
// the per-channel scale/saturate stage feeding the DAC.
module dsp_tx_interp
    import dsp_tx_pkg::*;
#(
    parameter logic [SET_ADDR_W-1:0] BASE      = 8'd176,
    parameter int unsigned           WIDTH_INT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_stb,
    input  logic [SET_ADDR_W-1:0] set_addr,
    input  logic [SET_DATA_W-1:0] set_data,
    input  logic [31:0]           sample,
    input  logic                  sample_valid,
    output logic                  strobe,
    input  logic                  run,
    output logic [SAMPLE_W-1:0]   dac_i,
    output logic [SAMPLE_W-1:0]   dac_q,
    output logic [23:0]           phase,
    output logic                  underrun
);

    logic [31:0]         phase_inc_q, phase_inc_d;
    logic [SAMPLE_W-1:0] scale_i_q,   scale_i_d;
    logic [SAMPLE_W-1:0] scale_q_q,   scale_q_d;
    logic [RATE_W-1:0]   rate_q,      rate_d;
    logic [RATE_W-1:0]   cnt_q,       cnt_d;
    logic [RATE_W-1:0]   reload;
    logic [31:0]         phase_acc_q, phase_acc_d;
    iq_sample_t          in_reg_q,    in_reg_d;
    logic                strb_d1_q,   strb_d1_d;
    logic                underrun_q,  underrun_d;
    logic [SAMPLE_W-1:0] dac_i_q,     dac_i_d;
    logic [SAMPLE_W-1:0] dac_q_q,     dac_q_d;
    logic [SHIFT_W-1:0]  shift;
    logic signed [SAMPLE_W-1:0] cic_i, cic_q;

    // Signed sample times unsigned Q2.14 gain, clamped to 16 bits.
    function automatic logic [SAMPLE_W-1:0] scale_sat(input logic signed [SAMPLE_W-1:0] x,
                                                      input logic [SAMPLE_W-1:0] k);
        logic signed [32:0] p;
        p = 33'(x) * $signed({17'b0, k});
        if ((p[32:29] == 4'b0000) || (p[32:29] == 4'b1111)) begin
            return p[29:14];
        end
        return p[32] ? 16'h8000 : 16'h7FFF;
    endfunction

    // A sample is consumed whenever the running down-counter sits at zero.
    assign strobe   = run & rst_n & (cnt_q == '0);
    assign shift    = clog2_rate(rate_q);
    assign dac_i    = dac_i_q;
    assign dac_q    = dac_q_q;
    assign phase    = phase_acc_q[31:8];
    assign underrun = underrun_q;

    // Next-state for settings, strober, NCO, capture and scale stage.
    always_comb begin
        phase_inc_d = phase_inc_q;
        scale_i_d   = scale_i_q;
        scale_q_d   = scale_q_q;
        rate_d      = rate_q;
        in_reg_d    = in_reg_q;
        strb_d1_d   = strobe;
        underrun_d  = underrun_q;
        if (set_stb) begin
            if (set_addr == BASE + REG_PHASE_INC) begin
                phase_inc_d = set_data;
            end
            if (set_addr == BASE + REG_SCALE) begin
                scale_i_d = set_data[31:16];
                scale_q_d = set_data[15:0];
            end
            if (set_addr == BASE + REG_RATE) begin
                rate_d = set_data[RATE_W-1:0];
            end
        end
        // Reload sees a same-cycle rate write so it applies from this strobe on.
        reload      = (rate_d <= 8'd1) ? 8'd0 : rate_d - 8'd1;
        cnt_d       = strobe ? reload : cnt_q - 8'd1;
        phase_acc_d = phase_acc_q + phase_inc_q;
        if (strobe) begin
            in_reg_d = sample_valid ? iq_sample_t'(sample) : '0;
            if (!sample_valid) begin
                underrun_d = 1'b1;
            end
        end
        dac_i_d = scale_sat(cic_i, scale_i_q);
        dac_q_d = scale_sat(cic_q, scale_q_q);
        if (!run) begin
            cnt_d       = '0;
            phase_acc_d = '0;
            in_reg_d    = '0;
            strb_d1_d   = 1'b0;
            underrun_d  = 1'b0;
            dac_i_d     = '0;
            dac_q_d     = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_inc_q <= '0;
            scale_i_q   <= '0;
            scale_q_q   <= '0;
            rate_q      <= '0;
            cnt_q       <= '0;
            phase_acc_q <= '0;
            in_reg_q    <= '0;
            strb_d1_q   <= 1'b0;
            underrun_q  <= 1'b0;
            dac_i_q     <= '0;
            dac_q_q     <= '0;
        end else begin
            phase_inc_q <= phase_inc_d;
            scale_i_q   <= scale_i_d;
            scale_q_q   <= scale_q_d;
            rate_q      <= rate_d;
            cnt_q       <= cnt_d;
            phase_acc_q <= phase_acc_d;
            in_reg_q    <= in_reg_d;
            strb_d1_q   <= strb_d1_d;
            underrun_q  <= underrun_d;
            dac_i_q     <= dac_i_d;
            dac_q_q     <= dac_q_d;
        end
    end

    tx_cic_interp #(.WIDTH_INT(WIDTH_INT)) u_cic_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~run),
        .en     (strb_d1_q),
        .din    ($signed(in_reg_q.i)),
        .shift  (shift),
        .dout_c (cic_i)
    );

    tx_cic_interp #(.WIDTH_INT(WIDTH_INT)) u_cic_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~run),
        .en     (strb_d1_q),
        .din    ($signed(in_reg_q.q)),
        .shift  (shift),
        .dout_c (cic_q)
    );

endmodule

// File: tb/tb_dsp_tx_interp.sv
// Directed bench for dsp_tx_interp: reset, identity path, interpolation,
// strobe cadence, saturation, NCO wrap and underrun behaviour.
module tb_dsp_tx_interp;
    import dsp_tx_pkg::*;

    localparam logic [7:0] BASE = 8'd176;

    logic        clk;
    logic        rst_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] sample;
    logic        sample_valid;
    logic        strobe;
    logic        run;
    logic [15:0] dac_i;
    logic [15:0] dac_q;
    logic [23:0] phase;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    dsp_tx_interp #(.BASE(BASE), .WIDTH_INT(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .strobe       (strobe),
        .run          (run),
        .dac_i        (dac_i),
        .dac_q        (dac_q),
        .phase        (phase),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] smp;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        step();
        set_stb  = 1'b0;
    endtask

    initial begin
        logic [15:0] imp_exp [16];
        logic [15:0] cst_exp [16];
        logic        cad_exp [12];

        rst_n        = 1'b0;
        run          = 1'b1;
        set_stb      = 1'b0;
        set_addr     = '0;
        set_data     = '0;
        sample       = '0;
        sample_valid = 1'b1;

        // Identity path at R=1: output equals input six cycles later.
        tbl[0]  = '{32'h1000_F000, 16'h0000, 16'h0000};
        tbl[1]  = '{32'h1000_F000, 16'h0000, 16'h0000};
        tbl[2]  = '{32'h1000_F000, 16'h0000, 16'h0000};
        tbl[3]  = '{32'h1000_F000, 16'h0000, 16'h0000};
        tbl[4]  = '{32'h7FFF_8000, 16'h0000, 16'h0000};
        tbl[5]  = '{32'h0000_0000, 16'h0000, 16'h0000};
        tbl[6]  = '{32'h0000_0000, 16'h1000, 16'hF000};
        tbl[7]  = '{32'h0123_FEDC, 16'h1000, 16'hF000};
        tbl[8]  = '{32'h0000_0000, 16'h1000, 16'hF000};
        tbl[9]  = '{32'h0000_0000, 16'h1000, 16'hF000};
        tbl[10] = '{32'h0000_0000, 16'h7FFF, 16'h8000};
        tbl[11] = '{32'h0000_0000, 16'h0000, 16'h0000};
        tbl[12] = '{32'h0000_0000, 16'h0000, 16'h0000};
        tbl[13] = '{32'h0000_0000, 16'h0123, 16'hFEDC};
        tbl[14] = '{32'h0000_0000, 16'h0000, 16'h0000};
        tbl[15] = '{32'h0000_0000, 16'h0000, 16'h0000};

        imp_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0400, 16'h0800,
                    16'h0C00, 16'h1000, 16'h0C00, 16'h0800, 16'h0400, 16'h0, 16'h0, 16'h0};
        cst_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0400, 16'h0800,
                    16'h0C00, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        cad_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held with run=1 and random traffic.
        for (int c = 0; c < 4; c++) begin
            sample       = $urandom;
            sample_valid = 1'($urandom);
            step();
        end
        chk("rst_dac_i", 32'(dac_i), 32'h0);
        chk("rst_dac_q", 32'(dac_q), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);

        sample_valid = 1'b1;
        rst_n        = 1'b1;
        #1;
        chk("first_strobe", 32'(strobe), 32'h1);
        step();
        run = 1'b0;
        step();

        write_reg(BASE + REG_SCALE, {SCALE_UNITY, SCALE_UNITY});
        write_reg(BASE + REG_RATE, 32'd1);

        for (int k = 0; k < 16; k++) begin
            run          = 1'b1;
            sample_valid = 1'b1;
            sample       = tbl[k].smp;
            #1;
            chk($sformatf("id_strobe[%0d]", k), 32'(strobe), 32'h1);
            chk($sformatf("id_dac_i[%0d]", k), 32'(dac_i), 32'(tbl[k].exp_i));
            chk($sformatf("id_dac_q[%0d]", k), 32'(dac_q), 32'(tbl[k].exp_q));
            step();
        end
        chk("id_underrun", 32'(underrun), 32'h0);
        run = 1'b0;
        step();

        // R=4 impulse: triangular response after the shift by 2.
        write_reg(BASE + REG_RATE, 32'd4);
        for (int k = 0; k < 16; k++) begin
            run    = 1'b1;
            sample = (k == 0) ? 32'h1000_0000 : 32'h0;
            #1;
            chk($sformatf("imp_strobe[%0d]", k), 32'(strobe), 32'((k % 4) == 0));
            chk($sformatf("imp_dac_i[%0d]", k), 32'(dac_i), 32'(imp_exp[k]));
            step();
        end
        run = 1'b0;
        step();

        // R=4 constant input settles at unity.
        for (int k = 0; k < 16; k++) begin
            run    = 1'b1;
            sample = 32'h1000_0000;
            #1;
            chk($sformatf("cst_dac_i[%0d]", k), 32'(dac_i), 32'(cst_exp[k]));
            chk($sformatf("cst_dac_q[%0d]", k), 32'(dac_q), 32'h0);
            step();
        end
        run = 1'b0;
        step();
        chk("flush_dac_i", 32'(dac_i), 32'h0);

        // Cadence with mid-run rate writes, including one coinciding with a strobe.
        sample = 32'h0;
        for (int k = 0; k < 12; k++) begin
            run     = 1'b1;
            set_stb = (k == 1) || (k == 7);
            set_addr = BASE + REG_RATE;
            set_data = (k == 1) ? 32'd1 : 32'd4;
            #1;
            chk($sformatf("cad_strobe[%0d]", k), 32'(strobe), 32'(cad_exp[k]));
            step();
        end
        set_stb = 1'b0;
        run     = 1'b0;
        step();

        // Saturation with maximum gain.
        write_reg(BASE + REG_SCALE, 32'hFFFF_FFFF);
        write_reg(BASE + REG_RATE, 32'd1);
        run    = 1'b1;
        sample = 32'h7FFF_8000;
        for (int k = 0; k < 8; k++) step();
        chk("sat_pos_i", 32'(dac_i), 32'h7FFF);
        chk("sat_neg_q", 32'(dac_q), 32'h8000);
        sample = 32'h8000_7FFF;
        for (int k = 0; k < 8; k++) step();
        chk("sat_neg_i", 32'(dac_i), 32'h8000);
        chk("sat_pos_q", 32'(dac_q), 32'h7FFF);
        run = 1'b0;
        step();

        // NCO: 0x010000 per cycle on phase, wrapping after 0xFF0000.
        write_reg(BASE + REG_SCALE, {SCALE_UNITY, SCALE_UNITY});
        write_reg(BASE + REG_PHASE_INC, 32'h0100_0000);
        sample = 32'h0;
        for (int k = 0; k < 260; k++) begin
            logic [31:0] e;
            run = 1'b1;
            e   = 32'(k) << 16;
            #1;
            chk($sformatf("nco_phase[%0d]", k), 32'(phase), {8'h0, e[23:0]});
            step();
        end
        run = 1'b0;
        step();

        // Underrun at R=2: one missing sample injects a zero and sticks.
        write_reg(BASE + REG_RATE, 32'd2);
        for (int k = 0; k < 15; k++) begin
            run          = 1'b1;
            sample       = 32'h1000_0000;
            sample_valid = (k != 4);
            #1;
            if (k == 3)  chk("ur_before", 32'(underrun), 32'h0);
            if (k == 5)  chk("ur_set", 32'(underrun), 32'h1);
            if (k == 10) chk("ur_dac_dip_in", 32'(dac_i), 32'h0800);
            if (k == 11) chk("ur_dac_zero", 32'(dac_i), 32'h0);
            if (k == 13) chk("ur_dac_recover", 32'(dac_i), 32'h1000);
            if (k == 14) chk("ur_sticky", 32'(underrun), 32'h1);
            step();
        end
        run          = 1'b0;
        sample_valid = 1'b1;
        step();
        chk("ur_clear", 32'(underrun), 32'h0);

        // Reset asserted mid-burst on what would be a strobe cycle.
        for (int k = 0; k < 2; k++) begin
            run = 1'b1;
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", 32'(strobe), 32'h0);
        chk("mid_rst_dac_i", 32'(dac_i), 32'h0);
        chk("mid_rst_phase", 32'(phase), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
